// File: rtl/counter_pkg.sv
// Shared constants for the mod-N up/down counter slice.
// Mode encoding and prescaler sizing.
package counter_pkg;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam int   PRESCALE_W   = 16;

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler: down-counter that ticks on every PRESCALE-th
// enabled cycle, then reloads.
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("count_prescaler: PRESCALE out of range 1..65535");
    end

    localparam logic [PRESCALE_W-1:0] TOP = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= TOP;
        end else if (restart) begin
            cnt <= TOP;
        end else if (en) begin
            cnt <= tick ? TOP : cnt - PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Mod-N up/down counter with prescaled enable, wrap and one-shot modes,
// synchronous clear/load and a one-cycle wrap pulse.
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH     = 3,
    parameter longint MODULUS   = 8,
    parameter longint RESET_VAL = MODULUS - 1,
    parameter int     PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped,
    output logic             done
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_n_updown_counter: WIDTH out of range 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
        $error("mod_n_updown_counter: MODULUS out of range 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
        $error("mod_n_updown_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST   = WIDTH'(RESET_VAL);

    logic             tick;
    logic             step;
    logic             restart;
    logic [WIDTH:0]   inc_x;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] load_sat;

    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .restart(restart),
        .tick   (tick)
    );

    // One extra bit so MODULUS = 2**WIDTH compares without overflow.
    assign inc_x    = {1'b0, count} + (WIDTH + 1)'(1);
    assign inc      = (inc_x >= MOD_X) ? '0 : inc_x[WIDTH-1:0];
    assign dec      = (count == '0) ? LAST : count - WIDTH'(1);
    assign load_sat = ({1'b0, load_val} >= MOD_X) ? LAST : load_val;

    assign tc      = up ? (count == LAST) : (count == '0);
    assign step    = en && tick && !done;
    assign restart = clear || load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= RST;
            wrapped <= 1'b0;
            done    <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            priority case (1'b1)
                clear: begin
                    count <= RST;
                    done  <= 1'b0;
                end
                load: begin
                    count <= load_sat;
                    done  <= 1'b0;
                end
                step: begin
                    if (mode == MODE_ONESHOT && tc) begin
                        done <= 1'b1;
                    end else begin
                        count   <= up ? inc : dec;
                        wrapped <= tc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: three configurations checked every
// cycle against an arithmetic model, plus hand-computed sequences.
module tb_mod_n_updown_counter;

    typedef struct {
        int cnt;
        bit wr;
        bit dn;
        int ph;
    } m_t;

    logic clk = 0;
    logic rst = 0;
    logic rst2 = 0;
    wire  r2 = rst | rst2;
    bit   run = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic       en0 = 0, up0 = 0, mode0 = 0, clr0 = 0, ld0 = 0;
    logic [2:0] lv0 = 0, count0;
    logic       tc0, wrapped0, done0;

    logic       en1 = 0, up1 = 0, mode1 = 0, clr1 = 0, ld1 = 0;
    logic [3:0] lv1 = 0, count1;
    logic       tc1, wrapped1, done1;

    logic       en2 = 0, up2 = 0, mode2 = 0, clr2 = 0, ld2 = 0;
    logic [3:0] lv2 = 0, count2;
    logic       tc2, wrapped2, done2;

    mod_n_updown_counter d0 (
        .clk(clk), .reset(rst), .en(en0), .up(up0), .mode(mode0),
        .clear(clr0), .load(ld0), .load_val(lv0), .count(count0),
        .tc(tc0), .wrapped(wrapped0), .done(done0)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) d1 (
        .clk(clk), .reset(rst), .en(en1), .up(up1), .mode(mode1),
        .clear(clr1), .load(ld1), .load_val(lv1), .count(count1),
        .tc(tc1), .wrapped(wrapped1), .done(done1)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) d2 (
        .clk(clk), .reset(r2), .en(en2), .up(up2), .mode(mode2),
        .clear(clr2), .load(ld2), .load_val(lv2), .count(count2),
        .tc(tc2), .wrapped(wrapped2), .done(done2)
    );

    function automatic m_t rst_state(int rv);
        m_t s;
        s.cnt = rv;
        s.wr  = 0;
        s.dn  = 0;
        s.ph  = 0;
        return s;
    endfunction

    // ph counts enabled cycles since the last tick or restart.
    function automatic m_t nxt(m_t s, bit en, bit up, bit mode, bit clr,
                               bit ld, int lv, int M, int RV, int P);
        m_t n;
        bit tick;
        bit term;
        n = s;
        n.wr = 0;
        tick = 0;
        if (clr) begin
            n.cnt = RV; n.dn = 0; n.ph = 0;
        end else if (ld) begin
            n.cnt = (lv >= M) ? M - 1 : lv; n.dn = 0; n.ph = 0;
        end else begin
            if (en) begin
                n.ph = s.ph + 1;
                if (n.ph == P) begin
                    tick = 1;
                    n.ph = 0;
                end
            end
            if (tick && !s.dn) begin
                term = up ? (s.cnt == M - 1) : (s.cnt == 0);
                if (mode && term) n.dn = 1;
                else begin
                    n.cnt = up ? (s.cnt + 1) % M : (s.cnt + M - 1) % M;
                    n.wr  = term;
                end
            end
        end
        return n;
    endfunction

    m_t m0, m1, m2;

    always @(posedge clk or posedge rst)
        if (rst) m0 <= rst_state(7);
        else m0 <= nxt(m0, en0, up0, mode0, clr0, ld0, int'(lv0), 8, 7, 1);

    always @(posedge clk or posedge rst)
        if (rst) m1 <= rst_state(9);
        else m1 <= nxt(m1, en1, up1, mode1, clr1, ld1, int'(lv1), 10, 9, 1);

    always @(posedge clk or posedge r2)
        if (r2) m2 <= rst_state(9);
        else m2 <= nxt(m2, en2, up2, mode2, clr2, ld2, int'(lv2), 10, 9, 3);

    task automatic check(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_dut(string nm, int c, bit t, bit w, bit d,
                           m_t m, bit up, int M);
        check({nm, ".count"}, c, m.cnt);
        check({nm, ".tc"}, int'(t), int'(up ? (m.cnt == M - 1) : (m.cnt == 0)));
        check({nm, ".wrapped"}, int'(w), int'(m.wr));
        check({nm, ".done"}, int'(d), int'(m.dn));
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk_dut("d0", int'(count0), tc0, wrapped0, done0, m0, up0, 8);
            chk_dut("d1", int'(count1), tc1, wrapped1, done1, m1, up1, 10);
            chk_dut("d2", int'(count2), tc2, wrapped2, done2, m2, up2, 10);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    int seq_a[8] = '{6, 5, 4, 3, 2, 1, 0, 7};
    int seq_os[3] = '{2, 1, 0};

    initial begin
        #1 rst = 1;
        #1 run = 1;
        cyc();
        cyc();

        // Defaults: count down through the wrap.
        rst = 0; en0 = 1; up0 = 0; mode0 = 0;
        check("A.reset_count", int'(count0), 7);
        check("A.reset_done", int'(done0), 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check($sformatf("A.count[%0d]", i), int'(count0), seq_a[i]);
            check($sformatf("A.wrapped[%0d]", i), int'(wrapped0), int'(i == 7));
        end
        en0 = 0;
        cyc();
        check("A.wrap_pulse_end", int'(wrapped0), 0);

        // Modulus 10 counting up from 0.
        ld1 = 1; lv1 = 0; up1 = 1; en1 = 1;
        cyc();
        check("B.load0", int'(count1), 0);
        ld1 = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            check($sformatf("B.count[%0d]", i), int'(count1), i % 10);
            check($sformatf("B.wrapped[%0d]", i), int'(wrapped1), int'(i == 10));
        end
        ld1 = 1; lv1 = 12;
        cyc();
        check("B.load_sat", int'(count1), 9);

        // One-shot down from 3.
        mode1 = 1; up1 = 0; lv1 = 3;
        cyc();
        check("C.load3", int'(count1), 3);
        ld1 = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("C.count[%0d]", i), int'(count1), seq_os[i]);
        end
        cyc();
        check("C.done_set", int'(done1), 1);
        check("C.done_count", int'(count1), 0);
        check("C.no_wrap", int'(wrapped1), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("C.hold[%0d]", i), int'(count1), 0);
        end
        ld1 = 1; lv1 = 5;
        cyc();
        check("C.load5", int'(count1), 5);
        check("C.done_clr", int'(done1), 0);
        clr1 = 1; lv1 = 4;
        cyc();
        check("C.clear_over_load", int'(count1), 9);
        clr1 = 0; ld1 = 0;

        // Direction changes take effect on the next step.
        mode1 = 0; up1 = 1;
        cyc();
        check("D.up_wrap", int'(count1), 0);
        up1 = 0;
        cyc();
        check("D.down_wrap", int'(count1), 9);
        up1 = 1;
        cyc();
        check("D.up_again", int'(count1), 0);
        en1 = 0;

        // Prescale 3.
        en2 = 1; up2 = 1;
        cyc(); cyc();
        check("E.pre_hold", int'(count2), 9);
        cyc();
        check("E.first_step", int'(count2), 0);
        check("E.first_wrap", int'(wrapped2), 1);
        cyc(); cyc();
        check("E.hold2", int'(count2), 0);
        cyc();
        check("E.second_step", int'(count2), 1);
        en2 = 0;
        cyc(); cyc();
        check("E.en_low", int'(count2), 1);
        en2 = 1;
        cyc(); cyc();
        check("E.delayed", int'(count2), 1);
        cyc();
        check("E.third_step", int'(count2), 2);
        cyc();
        rst2 = 1;
        #1;
        check("E.async_reset", int'(count2), 9);
        cyc();
        rst2 = 0;
        cyc(); cyc();
        check("E.post_reset_hold", int'(count2), 9);
        cyc();
        check("E.post_reset_step", int'(count2), 0);
        en2 = 0;
        cyc();

        run = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
